fetch_sequencer: RTL and testbench



---
 rtl/fetch_sequencer.sv | 117 +++++++++++
 tb/tb_fetch_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Multicycle instruction-fetch controller: owns the PC and walks each instruction
// through BOOT -> FETCH -> WAIT_EXEC, halting with a sticky fault on timeout or misaligned redirect.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_1000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] pc,
    output logic        fetch_fault,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_BOOT      = 2'd0,
        S_FETCH     = 2'd1,
        S_WAIT_EXEC = 2'd2,
        S_HALT      = 2'd3
    } state_t;

    localparam logic [7:0] W_MAX = MAX_WAIT[7:0];

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_instr_valid;
    logic        r_fault;
    logic [7:0]  r_wait_cnt;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_instr_nxt;
    logic        w_instr_valid_nxt;
    logic        w_fault_nxt;
    logic [7:0]  w_wait_cnt_nxt;

    // Handshakes: imem_req is high for every FETCH cycle and a word is taken on the
    // first edge where imem_req && imem_ready; the execute stage retires on any edge
    // in WAIT_EXEC with exec_done high, and redirect only counts alongside exec_done.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_instr_nxt       = r_instr;
        w_instr_valid_nxt = 1'b0;
        w_fault_nxt       = r_fault;
        w_wait_cnt_nxt    = r_wait_cnt;
        case (r_state)
            S_BOOT: w_state_nxt = S_FETCH;
            S_FETCH: begin
                if (imem_ready) begin
                    w_instr_nxt       = imem_rdata;
                    w_instr_valid_nxt = 1'b1;
                    w_wait_cnt_nxt    = 8'd0;
                    w_state_nxt       = S_WAIT_EXEC;
                end else if (r_wait_cnt == W_MAX) begin
                    w_fault_nxt = 1'b1;
                    w_state_nxt = S_HALT;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end
            end
            S_WAIT_EXEC: begin
                if (exec_done) begin
                    if (!redirect) begin
                        w_pc_nxt    = r_pc + 32'd4;
                        w_state_nxt = S_FETCH;
                    end else if (redirect_target[1:0] == 2'b00) begin
                        w_pc_nxt    = redirect_target;
                        w_state_nxt = S_FETCH;
                    end else begin
                        // Misaligned target: keep the faulting instruction's PC for debug.
                        w_fault_nxt = 1'b1;
                        w_state_nxt = S_HALT;
                    end
                end
            end
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_PC;
            r_instr       <= 32'd0;
            r_instr_valid <= 1'b0;
            r_fault       <= 1'b0;
            r_wait_cnt    <= 8'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_fault       <= w_fault_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
        end
    end

    assign imem_req    = (r_state == S_FETCH);
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign fetch_fault = r_fault;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: fetched {pc, instr} pairs go through a scoreboard queue
// checked on every instr_valid pulse; control/fault behaviour is checked inline.
module tb_fetch_sequencer;

    localparam logic [31:0] KEY = 32'hCAFE_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic        instr_valid;
    logic        exec_done = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'd0;
    logic [31:0] pc;
    logic        fetch_fault;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    fetch_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .instr(instr), .instr_valid(instr_valid),
        .exec_done(exec_done), .redirect(redirect), .redirect_target(redirect_target),
        .pc(pc), .fetch_fault(fetch_fault), .dbg_state(dbg_state)
    );

    // clock / memory model
    always #5 clk = ~clk;
    assign imem_rdata = imem_addr ^ KEY;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // wait for FETCH, check address, then supply the word after 'delay' not-ready cycles
    task automatic fetch_word(input logic [31:0] exp_addr, input logic [31:0] exp_instr, input int delay);
        int n = 0;
        while (!imem_req && n < 40) begin
            tick();
            n++;
        end
        if (!imem_req) begin
            checks++;
            errors++;
            $display("FAIL fetch_req_timeout: imem_req=0 after %0d cycles, expected 1", n);
            return;
        end
        check("fetch_addr", imem_addr, exp_addr);
        exp_q.push_back({exp_addr, exp_instr});
        repeat (delay) tick();
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
    endtask

    task automatic exec_step(input int delay, input logic redir, input logic [31:0] tgt);
        repeat (delay) tick();
        exec_done = 1'b1;
        redirect = redir;
        redirect_target = tgt;
        tick();
        exec_done = 1'b0;
        redirect = 1'b0;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (instr_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_valid: pc=%h instr=%h with nothing expected", pc, instr);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({pc, instr} !== e) begin
                    errors++;
                    $display("FAIL sb_instr: got pc=%h instr=%h expected pc=%h instr=%h",
                             pc, instr, e[63:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        // reset state
        tick();
        tick();
        check("rst_pc", pc, 32'h0000_1000);
        check("rst_instr", instr, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_fault", {31'd0, fetch_fault}, 32'd0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("boot_state", {30'd0, dbg_state}, 32'd0);
        check("boot_req", {31'd0, imem_req}, 32'd0);

        // straight-line, 2 cycles per instruction
        fetch_word(32'h0000_1000, 32'hCAFE_1000, 0);
        exec_step(0, 1'b0, 32'd0);
        check("b2b_req", {31'd0, imem_req}, 32'd1);
        fetch_word(32'h0000_1004, 32'hCAFE_1004, 0);
        exec_step(0, 1'b0, 32'd0);
        check("b2b_req2", {31'd0, imem_req}, 32'd1);
        fetch_word(32'h0000_1008, 32'hCAFE_1008, 0);

        // taken branch, then back to 0x1008 with a memory wait
        exec_step(2, 1'b1, 32'h0000_2000);
        fetch_word(32'h0000_2000, 32'hCAFE_2000, 0);
        exec_step(0, 1'b1, 32'h0000_1008);
        fetch_word(32'h0000_1008, 32'hCAFE_1008, 3);
        check("wait_no_fault", {31'd0, fetch_fault}, 32'd0);
        exec_step(1, 1'b0, 32'd0);
        fetch_word(32'h0000_100C, 32'hCAFE_100C, 0);

        // redirect without exec_done is ignored
        redirect = 1'b1;
        redirect_target = 32'h0000_3000;
        tick();
        redirect = 1'b0;
        check("stray_redirect_pc", pc, 32'h0000_100C);
        check("stray_redirect_state", {30'd0, dbg_state}, 32'd2);

        // PC wrap
        exec_step(0, 1'b1, 32'hFFFF_FFFC);
        fetch_word(32'hFFFF_FFFC, 32'h3501_FFFC, 0);
        exec_step(0, 1'b0, 32'd0);
        check("wrap_pc", pc, 32'h0000_0000);

        // exec_done during FETCH has no effect
        exec_done = 1'b1;
        tick();
        tick();
        exec_done = 1'b0;
        check("fetch_done_pc", pc, 32'h0000_0000);
        check("fetch_done_state", {30'd0, dbg_state}, 32'd1);
        fetch_word(32'h0000_0000, 32'hCAFE_0000, 0);

        // misaligned redirect
        exec_step(0, 1'b1, 32'h0000_2002);
        check("misal_fault", {31'd0, fetch_fault}, 32'd1);
        check("misal_pc", pc, 32'h0000_0000);
        check("misal_req", {31'd0, imem_req}, 32'd0);
        imem_ready = 1'b1;
        exec_done = 1'b1;
        repeat (4) tick();
        imem_ready = 1'b0;
        exec_done = 1'b0;
        check("halt_state", {30'd0, dbg_state}, 32'd3);
        check("halt_req", {31'd0, imem_req}, 32'd0);
        check("halt_pc", pc, 32'h0000_0000);
        check("halt_fault", {31'd0, fetch_fault}, 32'd1);

        // reset out of HALT, then async reset mid-fetch with ready high
        rst_n = 1'b0;
        #1;
        check("halt_rst_fault", {31'd0, fetch_fault}, 32'd0);
        tick();
        rst_n = 1'b1;
        fetch_word(32'h0000_1000, 32'hCAFE_1000, 0);
        exec_step(0, 1'b0, 32'd0);
        imem_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_pc", pc, 32'h0000_1000);
        check("async_instr", instr, 32'd0);
        check("async_valid", {31'd0, instr_valid}, 32'd0);
        check("async_fault", {31'd0, fetch_fault}, 32'd0);
        check("async_req", {31'd0, imem_req}, 32'd0);
        tick();
        tick();
        imem_ready = 1'b0;
        rst_n = 1'b1;

        // timeout: fault on the 16th consecutive not-ready FETCH cycle
        tick();
        check("to_req", {31'd0, imem_req}, 32'd1);
        repeat (15) tick();
        check("to_15_fault", {31'd0, fetch_fault}, 32'd0);
        check("to_15_req", {31'd0, imem_req}, 32'd1);
        tick();
        check("to_16_fault", {31'd0, fetch_fault}, 32'd1);
        check("to_16_req", {31'd0, imem_req}, 32'd0);
        imem_ready = 1'b1;
        repeat (3) tick();
        imem_ready = 1'b0;
        check("to_halt_state", {30'd0, dbg_state}, 32'd3);
        check("to_halt_pc", pc, 32'h0000_1000);

        tick();
        check("sb_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
